pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. The WIDTH/4 groups are split into STAGES equal slices. Each pipeline stage resolves one slice using the carry registered by the previous stage. A valid/ready handshake on both sides supports back-pressure. The block is the wide-operand arithmetic stage for datapaths that have outgrown the 8-bit ripple-of-groups adder.

---
 rtl/pipelined_cla_adder_if.sv | 35 +++
 rtl/pipelined_cla_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// out_ovf exists only when CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
`ifdef CLA_OVF_EN
  logic             out_ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_carry, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry
`ifdef CLA_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_carry, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
`ifdef CLA_OVF_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, STAGES slices of 4-bit lookahead groups.
// Optional signed-overflow output enabled by defining CLA_OVF_EN.
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int NG  = WIDTH / 4;
  localparam int GPS = NG / STAGES;

  // Per-stage state: remaining operand bits, completed sum bits, slice carry-out, valid.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic [WIDTH-1:0] nx_a [STAGES];
  logic [WIDTH-1:0] nx_b [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic             adv;
`ifdef CLA_OVF_EN
  logic             st_m;
  logic             nx_m;
`endif

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign adv = bus.out_ready | ~st_v[STAGES-1];

  always_comb begin
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             sc;
    logic [4:0]       r;
    int               pk;
    int               g;
    sa = '0;
    sb = '0;
    ss = '0;
    sc = 1'b0;
    r  = '0;
    pk = 0;
    g  = 0;
    for (int k = 0; k < STAGES; k++) begin
      pk = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        sa = bus.in_a;
        sb = bus.in_sub ? ~bus.in_b : bus.in_b;
        ss = '0;
        sc = bus.in_sub | bus.in_carry;
      end else begin
        sa = st_a[pk];
        sb = st_b[pk];
        ss = st_s[pk];
        sc = st_c[pk];
      end
      for (int j = 0; j < GPS; j++) begin
        g            = (k * GPS + j) * 4;
        r            = cla4(sa[g +: 4], sb[g +: 4], sc);
        ss[g +: 4]   = r[3:0];
        sc           = r[4];
      end
      nx_a[k] = sa;
      nx_b[k] = sb;
      nx_s[k] = ss;
      nx_c[k] = sc;
    end
`ifdef CLA_OVF_EN
    // Carry into the MSB recovered from its sum bit and propagate term.
    nx_m = ss[WIDTH-1] ^ sa[WIDTH-1] ^ sb[WIDTH-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
        st_c[k] <= 1'b0;
        st_v[k] <= 1'b0;
      end
`ifdef CLA_OVF_EN
      st_m <= 1'b0;
`endif
    end else if (adv) begin
      st_v[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) st_v[k] <= st_v[k-1];
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= nx_a[k];
        st_b[k] <= nx_b[k];
        st_s[k] <= nx_s[k];
        st_c[k] <= nx_c[k];
      end
`ifdef CLA_OVF_EN
      st_m <= nx_m;
`endif
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = st_v[STAGES-1];
  assign bus.out_sum   = st_s[STAGES-1];
  assign bus.out_carry = st_c[STAGES-1];
`ifdef CLA_OVF_EN
  assign bus.out_ovf   = st_m ^ st_c[STAGES-1];
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, STAGES=2): directed table,
// back-pressure stream, mid-flight reset and a random handshake run.
module tb_pipelined_cla_adder;
  localparam int W = 16;
  localparam int S = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();
  pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t        vt [11];
  logic [17:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, carry, sum}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bp;
    logic [16:0] s;
    logic        c0;
    bp = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    s  = {1'b0, a} + {1'b0, bp} + {16'd0, c0};
    return {(a[15] == bp[15]) && (s[15] != a[15]), s};
  endfunction

  task automatic check_out(input string name, input logic [17:0] exp);
    check({name, " sum/carry"}, {15'd0, bus.out_carry, bus.out_sum}, {15'd0, exp[16:0]});
`ifdef CLA_OVF_EN
    check({name, " ovf"}, {31'd0, bus.out_ovf}, {31'd0, exp[17]});
`endif
  endtask

  task automatic apply_vec(input int i);
    @(negedge clk);
    bus.in_a     = vt[i].a;
    bus.in_b     = vt[i].b;
    bus.in_carry = vt[i].cin;
    bus.in_sub   = vt[i].sub;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check($sformatf("vec%0d early valid", i), {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
    check_out($sformatf("vec%0d", i), {vt[i].v, vt[i].c, vt[i].s});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int          got;
    int          stalls;
    int          stale;
    int          sent;
    int          rcvd;
    int          cyc;
    logic        was_stall;
    logic        pending;
    logic [16:0] held;
    logic [17:0] e;

    total = 0;
    bad   = 0;
    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[2]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vt[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[6]  = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[8]  = '{16'h1234, 16'h5678, 1'b0, 1'b1, 16'hBBBC, 1'b0, 1'b0};
    vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[10] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_carry = 1'b0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_sum/carry", {15'd0, bus.out_carry, bus.out_sum}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef CLA_OVF_EN
    check("reset ovf", {31'd0, bus.out_ovf}, 32'd0);
`endif

    for (int i = 0; i < 11; i++) apply_vec(i);

    // Stream of 8 beats with out_ready low during cycles 3..5.
    idx = 0;
    got = 0;
    stalls = 0;
    was_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (idx < 8);
      bus.in_a      = 16'(idx * 32'h1111);
      bus.in_b      = 16'h0F0F;
      bus.in_carry  = (idx % 2) == 1;
      bus.in_sub    = 1'b0;
      #1;
      check("stream in_ready", {31'd0, bus.in_ready},
            {31'd0, !(bus.out_valid && !bus.out_ready)});
      if (was_stall)
        check("stream stable", {15'd0, bus.out_carry, bus.out_sum}, {15'd0, held});
      was_stall = bus.out_valid && !bus.out_ready;
      if (was_stall) begin
        stalls++;
        held = {bus.out_carry, bus.out_sum};
      end
      if (bus.out_valid && bus.out_ready) begin
        check_out($sformatf("stream beat%0d", got),
                  model(16'(got * 32'h1111), 16'h0F0F, (got % 2) == 1, 1'b0));
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    check("stream count", got, 8);
    check("stream stalls", stalls, 3);

    // Two beats in flight, output held, then reset.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h1111;
    bus.in_b      = 16'h2222;
    @(negedge clk);
    bus.in_a      = 16'h3333;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("pre-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset drop out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset drop sum/carry", {15'd0, bus.out_carry, bus.out_sum}, 32'd0);
    check("reset drop in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("no stale beats", stale, 0);

    // Random handshake run against the reference model.
    sent = 0;
    rcvd = 0;
    cyc = 0;
    pending = 1'b0;
    q.delete();
    while (rcvd < 2000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!pending && sent < 2000 && $urandom_range(0, 3) != 0) begin
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_carry = 1'($urandom_range(0, 1));
        bus.in_sub   = 1'($urandom_range(0, 1));
        pending      = 1'b1;
      end
      bus.in_valid  = pending;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("random extra beat", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check_out($sformatf("random beat%0d", rcvd), e);
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_a, bus.in_b, bus.in_carry, bus.in_sub));
        sent++;
        pending = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("random count", rcvd, 2000);
    check("random queue empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
